// File: rtl/alu_rr_arbiter.sv
// Two-requester round-robin front end for one shared combinational ALU.
// At most one operation in flight: accept (IDLE) -> drive ALU (EXEC) -> respond (RESP).
module alu_rr_arbiter #(
   parameter int M = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [M-1:0] req0_a,
   input  logic [M-1:0] req0_b,
   input  logic [3:0]   req0_op,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [M-1:0] req1_a,
   input  logic [M-1:0] req1_b,
   input  logic [3:0]   req1_op,
   output logic         rsp0_valid,
   input  logic         rsp0_ready,
   output logic         rsp1_valid,
   input  logic         rsp1_ready,
   output logic [M-1:0] rsp_result,
   output logic [3:0]   rsp_flags,
   output logic [M-1:0] alu_a,
   output logic [M-1:0] alu_b,
   output logic [3:0]   alu_op,
   input  logic [M-1:0] alu_result,
   input  logic [3:0]   alu_flags
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]   state_q, state_d;
   logic         prio_q, prio_d;
   logic         gnt_q, gnt_d;
   logic [M-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
   logic [3:0]   op_q, op_d, flg_q, flg_d;

   logic any_req, sel, idle, rsp_take;

   assign any_req  = req0_valid | req1_valid;
   // Tie goes to prio; otherwise the lone valid requester wins.
   assign sel      = (req0_valid & req1_valid) ? prio_q : req1_valid;
   assign idle     = (state_q == IDLE);
   assign rsp_take = gnt_q ? rsp1_ready : rsp0_ready;

   assign req0_ready = ~rst & idle & any_req & ~sel;
   assign req1_ready = ~rst & idle & any_req & sel;
   assign rsp0_valid = (state_q == RESP) & ~gnt_q;
   assign rsp1_valid = (state_q == RESP) & gnt_q;

   assign alu_a      = a_q;
   assign alu_b      = b_q;
   assign alu_op     = op_q;
   assign rsp_result = res_q;
   assign rsp_flags  = flg_q;

   always_comb begin
      state_d = state_q;
      prio_d  = prio_q;
      gnt_d   = gnt_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      res_d   = res_q;
      flg_d   = flg_q;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               gnt_d   = sel;
               a_d     = sel ? req1_a  : req0_a;
               b_d     = sel ? req1_b  : req0_b;
               op_d    = sel ? req1_op : req0_op;
               state_d = EXEC;
            end
         end
         EXEC: begin
            res_d   = alu_result;
            flg_d   = alu_flags;
            state_d = RESP;
         end
         RESP: begin
            if (rsp_take) begin
               prio_d  = ~gnt_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         prio_q  <= 1'b0;
         gnt_q   <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         res_q   <= '0;
         flg_q   <= '0;
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
         gnt_q   <= gnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         res_q   <= res_d;
         flg_q   <= flg_d;
      end
   end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter with a small behavioural ALU attached.
module tb_alu_rr_arbiter;

   localparam int M = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         req0_valid = 0, req1_valid = 0;
   logic         req0_ready, req1_ready;
   logic [M-1:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
   logic [3:0]   req0_op = 0, req1_op = 0;
   logic         rsp0_valid, rsp1_valid;
   logic         rsp0_ready = 0, rsp1_ready = 0;
   logic [M-1:0] rsp_result, alu_a, alu_b, alu_result;
   logic [3:0]   rsp_flags, alu_op, alu_flags;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alu_rr_arbiter #(.M(M)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp_result(rsp_result), .rsp_flags(rsp_flags),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_result(alu_result), .alu_flags(alu_flags)
   );

   // Attached ALU: {N,Z,C,V}; C/V only meaningful for add.
   logic [M:0] sum;
   logic       c_f, v_f;
   always_comb begin
      sum = {1'b0, alu_a} + {1'b0, alu_b};
      c_f = 1'b0;
      v_f = 1'b0;
      case (alu_op)
         4'b0000, 4'b0001: begin
            alu_result = sum[M-1:0];
            c_f = sum[M];
            v_f = (alu_a[M-1] == alu_b[M-1]) && (sum[M-1] != alu_a[M-1]);
         end
         4'b0010: alu_result = alu_a & alu_b;
         4'b0011: alu_result = alu_a | alu_b;
         4'b0100: alu_result = alu_a ^ alu_b;
         4'b0101: alu_result = ~alu_a;
         default: alu_result = '0;
      endcase
      alu_flags = {alu_result[M-1], alu_result == '0, c_f, v_f};
   end

   task automatic chk(input string tag, input logic [M-1:0] got, input logic [M-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full transaction by requester id with zero-wait response consumption.
   task automatic do_op(input bit id, input logic [M-1:0] a, input logic [M-1:0] b,
                        input logic [3:0] op, input logic [M-1:0] er, input logic [3:0] ef);
      if (id) begin req1_valid = 1; req1_a = a; req1_b = b; req1_op = op; end
      else    begin req0_valid = 1; req0_a = a; req0_b = b; req0_op = op; end
      #1;
      chk("op_ready", {31'd0, id ? req1_ready : req0_ready}, 1);
      chk("op_other_ready", {31'd0, id ? req0_ready : req1_ready}, 0);
      tick();
      req0_valid = 0; req1_valid = 0;
      chk("op_exec_a", alu_a, a);
      chk("op_exec_op", {28'd0, alu_op}, {28'd0, op});
      chk("op_exec_novalid", {30'd0, rsp1_valid, rsp0_valid}, 0);
      tick();
      chk("op_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, id ? 2 : 1);
      chk("op_result", rsp_result, er);
      chk("op_flags", {28'd0, rsp_flags}, {28'd0, ef});
      if (id) rsp1_ready = 1; else rsp0_ready = 1;
      tick();
      rsp0_ready = 0; rsp1_ready = 0;
      chk("op_done", {30'd0, rsp1_valid, rsp0_valid}, 0);
   endtask

   initial begin
      // Reset state, with a request already pending
      req0_valid = 1;
      tick();
      chk("rst_ready", {30'd0, req1_ready, req0_ready}, 0);
      chk("rst_rspv", {30'd0, rsp1_valid, rsp0_valid}, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_result", rsp_result, 0);
      chk("rst_flags", {28'd0, rsp_flags}, 0);
      req0_valid = 0;
      rst = 0;
      tick();

      // Single add, overflow, xor-zero, not, and
      do_op(0, 32'd5, 32'd7, 4'b0000, 32'd12, 4'b0000);
      do_op(1, 32'h7FFF_FFFF, 32'd1, 4'b0000, 32'h8000_0000, 4'b1001);
      do_op(0, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 4'b0100, 32'd0, 4'b0100);
      do_op(1, 32'hFFFF_FFFF, 32'd1, 4'b0001, 32'd0, 4'b0110);
      do_op(0, 32'd0, 32'd9, 4'b0101, 32'hFFFF_FFFF, 4'b1000);
      do_op(1, 32'hF0F0_0000, 32'hFF00_00FF, 4'b0010, 32'hF000_0000, 4'b1000);

      // Contention from reset: strict alternation 0,1,0
      rst = 1; #1; rst = 0;
      req0_valid = 1; req0_a = 1; req0_b = 2; req0_op = 4'b0000;
      req1_valid = 1; req1_a = 32'hF0; req1_b = 32'h0F; req1_op = 4'b0011;
      #1;
      chk("ct_g1", {30'd0, req1_ready, req0_ready}, 1);
      tick();
      chk("ct_exec_ready", {30'd0, req1_ready, req0_ready}, 0);
      tick();
      chk("ct_rsp1", {30'd0, rsp1_valid, rsp0_valid}, 1);
      chk("ct_res1", rsp_result, 3);
      rsp0_ready = 1;
      tick();
      rsp0_ready = 0;
      chk("ct_g2", {30'd0, req1_ready, req0_ready}, 2);
      tick();
      tick();
      chk("ct_rsp2", {30'd0, rsp1_valid, rsp0_valid}, 2);
      chk("ct_res2", rsp_result, 32'hFF);
      rsp1_ready = 1;
      tick();
      rsp1_ready = 0;
      chk("ct_g3", {30'd0, req1_ready, req0_ready}, 1);

      // Backpressure on the third (req0) grant while req1 waits
      tick();
      req0_valid = 0;
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", {30'd0, rsp1_valid, rsp0_valid}, 1);
         chk("bp_result", rsp_result, 3);
         chk("bp_req1_ready", {31'd0, req1_ready}, 0);
         tick();
      end
      rsp0_ready = 1;
      tick();
      rsp0_ready = 0;
      chk("bp_g_req1", {30'd0, req1_ready, req0_ready}, 2);

      // Reset mid-op: req1 accepted, reset asserted in EXEC
      tick();
      chk("rm_exec_a", alu_a, 32'hF0);
      rst = 1;
      #1;
      chk("rm_alu_a", alu_a, 0);
      chk("rm_alu_op", {28'd0, alu_op}, 0);
      chk("rm_ready", {30'd0, req1_ready, req0_ready}, 0);
      req0_valid = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rm_rspv", {30'd0, rsp1_valid, rsp0_valid}, 0);
      end
      rst = 0;
      #1;
      chk("rm_tie_req0", {30'd0, req1_ready, req0_ready}, 1);
      req0_valid = 0; req1_valid = 0;
      #1;
      chk("rm_idle_ready", {30'd0, req1_ready, req0_ready}, 0);

      // Operand isolation: change request fields after the handshake
      req0_valid = 1; req0_a = 32'd10; req0_b = 32'd3; req0_op = 4'b0000;
      #1;
      chk("iso_ready", {31'd0, req0_ready}, 1);
      tick();
      req0_valid = 0; req0_a = 32'd1000; req0_op = 4'b0010;
      #1;
      chk("iso_exec_a", alu_a, 10);
      tick();
      chk("iso_valid", {30'd0, rsp1_valid, rsp0_valid}, 1);
      chk("iso_result", rsp_result, 13);
      rsp0_ready = 1;
      tick();
      rsp0_ready = 0;
      chk("iso_done", {30'd0, rsp1_valid, rsp0_valid}, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      n_err++;
      $display("FAIL timeout: got no end expected finish");
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $fatal(1);
   end

endmodule
